// File: rtl/pattern_loader_if.sv
// Read port of the upstream pattern FIFO, shared by the FIFO (slave) and the loader (master).
interface pattern_loader_if;
    logic [9:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_rd;

    modport master (input fifo_dout, input fifo_empty, output fifo_rd);
    modport slave  (output fifo_dout, output fifo_empty, input fifo_rd);
endinterface

// File: rtl/pattern_loader.sv
// Moves one subframe of 10-bit pattern words from the FIFO into the imager column
// shift registers, row by row, and keeps the per-frame subframe count.
module pattern_loader #(
    parameter int C_NUM_ROWS      = 160,
    parameter int C_WORDS_PER_ROW = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    pattern_loader_if.master fifo,
    input  logic             sub_start,
    input  logic [31:0]      num_pat,
    output logic [9:0]       pat_data,
    output logic             pat_clk,
    output logic             row_latch,
    output logic [7:0]       row_addr,
    output logic             sub_done,
    output logic             frame_done,
    output logic [31:0]      cnt_subc,
    output logic             busy,
    output logic             underflow
);
    localparam int             WCW       = (C_WORDS_PER_ROW > 1) ? $clog2(C_WORDS_PER_ROW) : 1;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(C_WORDS_PER_ROW - 1);
    localparam logic [7:0]     LAST_ROW  = 8'(C_NUM_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_RDWAIT,
        S_SETUP,
        S_CLKHI,
        S_LATCH,
        S_DONE
    } state_t;

    state_t         state, next_state;
    logic [WCW-1:0] word_cnt;
    logic [31:0]    cnt_next;
    logic           frame_hit;
    logic           first_word;

    assign cnt_next   = cnt_subc + 32'd1;
    assign frame_hit  = (cnt_next == num_pat);
    assign first_word = (row_addr == 8'd0) && (word_cnt == '0);

    // The read strobe must react to fifo_empty in the same FETCH cycle, otherwise a
    // stall would cost more than one cycle; it is a clean AND of a flop and the FIFO flag.
    assign fifo.fifo_rd = (state == S_FETCH) && !fifo.fifo_empty;

    always_comb begin
        // NOTE: next_state gets its default before the case so no path leaves it
        // unassigned; an unassigned path in always_comb would infer a latch.
        next_state = state;
        unique case (state)
            S_IDLE:   if (sub_start) next_state = S_FETCH;
            S_FETCH:  if (!fifo.fifo_empty) next_state = S_RDWAIT;
            S_RDWAIT: next_state = S_SETUP;
            S_SETUP:  next_state = S_CLKHI;
            S_CLKHI:  next_state = (word_cnt < LAST_WORD) ? S_FETCH : S_LATCH;
            S_LATCH:  next_state = (row_addr < LAST_ROW) ? S_FETCH : S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // NOTE: every flop uses the asynchronous active-low reset and non-blocking
    // assignments, so all registers update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Strobe outputs are decoded from next_state into flops so the pins never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_data   <= '0;
            pat_clk    <= 1'b0;
            row_latch  <= 1'b0;
            row_addr   <= '0;
            sub_done   <= 1'b0;
            frame_done <= 1'b0;
            cnt_subc   <= '0;
            busy       <= 1'b0;
            underflow  <= 1'b0;
            word_cnt   <= '0;
        end else begin
            pat_clk    <= (next_state == S_CLKHI);
            row_latch  <= (next_state == S_LATCH);
            sub_done   <= (next_state == S_DONE);
            busy       <= (next_state != S_IDLE);
            frame_done <= (next_state == S_DONE) && frame_hit;

            if (next_state == S_DONE) begin
                cnt_subc <= frame_hit ? 32'd0 : cnt_next;
            end

            case (state)
                S_IDLE: begin
                    if (sub_start) begin
                        row_addr  <= '0;
                        word_cnt  <= '0;
                        underflow <= 1'b0;
                    end
                end
                S_FETCH: begin
                    // Waiting for the very first word is normal start-up latency.
                    if (fifo.fifo_empty && !first_word) underflow <= 1'b1;
                end
                S_RDWAIT: pat_data <= fifo.fifo_dout;
                S_CLKHI:  word_cnt <= (word_cnt < LAST_WORD) ? word_cnt + 1'b1 : '0;
                S_LATCH: begin
                    if (row_addr < LAST_ROW) row_addr <= row_addr + 8'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
